// File: rtl/shared_bus_arbiter.sv
// shared_bus_arbiter: round-robin owner arbitration and broadcast mux for the
// shared snooping bus between NUM_CORES cores.
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   req_core            per-core request, held for the whole transaction
//   bus_*_in_c          per-core bus transaction slices (core i at slice i)
//   cache_hit_c         per-core snoop hit
//   grant, owner_id     registered one-hot ownership and owner index
//   bus_*_out           owner's transaction while owned, else BusNoN / zeros
//   snoop_hit           OR of non-owner snoop hits while owned
//   busy                registered, high while a core owns the bus
//   timeout_err         sticky flag, set when an owner holds too long
module shared_bus_arbiter #(
  parameter int unsigned NUM_CORES = 2,
  parameter int unsigned MAX_HOLD  = 64,
  localparam int unsigned IDW = (NUM_CORES > 2) ? $clog2(NUM_CORES) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CORES-1:0]      req_core,
  input  logic [32*NUM_CORES-1:0]   bus_data_in_c,
  input  logic [32*NUM_CORES-1:0]   bus_address_in_c,
  input  logic [2*NUM_CORES-1:0]    bus_operation_in_c,
  input  logic [NUM_CORES-1:0]      cache_hit_c,
  output logic [NUM_CORES-1:0]      grant,
  output logic [31:0]               bus_data_out,
  output logic [31:0]               bus_address_out,
  output logic [1:0]                bus_operation_out,
  output logic                      snoop_hit,
  output logic [IDW-1:0]            owner_id,
  output logic                      busy,
  output logic                      timeout_err
);

  localparam int unsigned HCW = $clog2(MAX_HOLD);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(MAX_HOLD - 1);
  localparam logic [IDW-1:0] LAST_ID   = IDW'(NUM_CORES - 1);

  typedef enum logic [1:0] {S_IDLE, S_OWN, S_GAP} state_t;

  state_t               state_q, state_d;
  logic [NUM_CORES-1:0] grant_d;
  logic [IDW-1:0]       owner_d, rr_ptr, rr_d, id_hi, id_any, win_id;
  logic [HCW-1:0]       hold_cnt, hold_d;
  logic                 busy_d, terr_d, found_hi, owner_req;

  // Round-robin winner: lowest requester at or above rr_ptr, else lowest overall.
  always_comb begin
    found_hi = 1'b0;
    id_hi    = '0;
    id_any   = '0;
    for (int i = int'(NUM_CORES) - 1; i >= 0; i--) begin
      if (req_core[i]) begin
        id_any = IDW'(i);
        if (IDW'(i) >= rr_ptr) begin
          id_hi    = IDW'(i);
          found_hi = 1'b1;
        end
      end
    end
    win_id = found_hi ? id_hi : id_any;
  end

  // grant is one-hot on the owner, so this is the owner's own request.
  assign owner_req = |(req_core & grant);

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    grant_d = grant;
    owner_d = owner_id;
    busy_d  = busy;
    rr_d    = rr_ptr;
    hold_d  = hold_cnt;
    terr_d  = timeout_err;
    case (state_q)
      S_IDLE: begin
        grant_d = '0;
        busy_d  = 1'b0;
        if (|req_core) begin
          state_d = S_OWN;
          grant_d = NUM_CORES'(1) << win_id;
          owner_d = win_id;
          busy_d  = 1'b1;
          hold_d  = '0;
        end
      end
      S_OWN: begin
        if (owner_req) begin
          // Timeout is only flagged; the owner keeps the bus.
          if (hold_cnt == HOLD_LAST) terr_d = 1'b1;
          else                       hold_d = hold_cnt + 1'b1;
        end else begin
          state_d = S_GAP;
          grant_d = '0;
          busy_d  = 1'b0;
          rr_d    = (owner_id == LAST_ID) ? '0 : owner_id + 1'b1;
        end
      end
      S_GAP: begin
        grant_d = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      grant       <= '0;
      owner_id    <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      rr_ptr      <= '0;
      hold_cnt    <= '0;
    end else begin
      state_q     <= state_d;
      grant       <= grant_d;
      owner_id    <= owner_d;
      busy        <= busy_d;
      timeout_err <= terr_d;
      rr_ptr      <= rr_d;
      hold_cnt    <= hold_d;
    end
  end

  // Broadcast mux of the owner's transaction.
  always_comb begin
    bus_data_out      = '0;
    bus_address_out   = '0;
    bus_operation_out = 2'b11;
    if (state_q == S_OWN) begin
      for (int i = 0; i < int'(NUM_CORES); i++) begin
        if (owner_id == IDW'(i)) begin
          bus_data_out      = bus_data_in_c[32*i +: 32];
          bus_address_out   = bus_address_in_c[32*i +: 32];
          bus_operation_out = bus_operation_in_c[2*i +: 2];
        end
      end
    end
  end

  assign snoop_hit = busy & |(cache_hit_c & ~grant);

endmodule

// File: tb/tb_shared_bus_arbiter.sv
// Bench for shared_bus_arbiter: directed two-core steps, then random four-core
// traffic against a reference arbiter, with a scoreboard of expected outputs.
module tb_shared_bus_arbiter;

  localparam int unsigned MH = 64;
  localparam int unsigned NB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic [1:0]  req_a, hit_a, grant_a, boo_a;
  logic [63:0] data_a, addr_a;
  logic [3:0]  op_a;
  logic [31:0] bdo_a, bao_a;
  logic        snoop_a, busy_a, terr_a;
  logic [0:0]  owner_a;

  logic [3:0]   req_b, hit_b, grant_b;
  logic [127:0] data_b, addr_b;
  logic [7:0]   op_b;
  logic [31:0]  bdo_b, bao_b;
  logic [1:0]   boo_b, owner_b;
  logic         snoop_b, busy_b, terr_b;

  shared_bus_arbiter #(.NUM_CORES(2), .MAX_HOLD(MH)) dut_a (
    .clk(clk), .reset(reset), .req_core(req_a),
    .bus_data_in_c(data_a), .bus_address_in_c(addr_a),
    .bus_operation_in_c(op_a), .cache_hit_c(hit_a),
    .grant(grant_a), .bus_data_out(bdo_a), .bus_address_out(bao_a),
    .bus_operation_out(boo_a), .snoop_hit(snoop_a), .owner_id(owner_a),
    .busy(busy_a), .timeout_err(terr_a)
  );

  shared_bus_arbiter #(.NUM_CORES(NB), .MAX_HOLD(16)) dut_b (
    .clk(clk), .reset(reset), .req_core(req_b),
    .bus_data_in_c(data_b), .bus_address_in_c(addr_b),
    .bus_operation_in_c(op_b), .cache_hit_c(hit_b),
    .grant(grant_b), .bus_data_out(bdo_b), .bus_address_out(bao_b),
    .bus_operation_out(boo_b), .snoop_hit(snoop_b), .owner_id(owner_b),
    .busy(busy_b), .timeout_err(terr_b)
  );

  typedef enum int {A_GRANT, A_OWNER, A_BUSY, A_OP, A_DATA, A_ADDR, A_SNOOP,
                    A_TERR, B_GRANT, B_OP, B_ADDR} sig_e;
  typedef struct {
    string       tag;
    sig_e        sig;
    logic [63:0] val;
  } exp_t;

  exp_t sbq[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  function automatic logic [63:0] observe(sig_e s);
    case (s)
      A_GRANT: return 64'(grant_a);
      A_OWNER: return 64'(owner_a);
      A_BUSY:  return 64'(busy_a);
      A_OP:    return 64'(boo_a);
      A_DATA:  return 64'(bdo_a);
      A_ADDR:  return 64'(bao_a);
      A_SNOOP: return 64'(snoop_a);
      A_TERR:  return 64'(terr_a);
      B_GRANT: return 64'(grant_b);
      B_OP:    return 64'(boo_b);
      B_ADDR:  return 64'(bao_b);
      default: return 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  task automatic push(input string tag, input sig_e s, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.sig = s;
    e.val = v;
    sbq.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [63:0] got;
    while (sbq.size() > 0) begin
      e   = sbq.pop_front();
      got = observe(e.sig);
      n_assert++;
      assert (got === e.val) else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, got, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic exp_idle_a(input string tag);
    push({tag, "_grant"}, A_GRANT, 64'd0);
    push({tag, "_busy"},  A_BUSY,  64'd0);
    push({tag, "_op"},    A_OP,    64'd3);
    push({tag, "_data"},  A_DATA,  64'd0);
    push({tag, "_addr"},  A_ADDR,  64'd0);
  endtask

  task automatic exp_own_a(input string tag, input logic [1:0] g, input logic o,
                           input logic [1:0] op, input logic [31:0] ad, input logic [31:0] d);
    push({tag, "_grant"}, A_GRANT, 64'(g));
    push({tag, "_owner"}, A_OWNER, 64'(o));
    push({tag, "_busy"},  A_BUSY,  64'd1);
    push({tag, "_op"},    A_OP,    64'(op));
    push({tag, "_addr"},  A_ADDR,  64'(ad));
    push({tag, "_data"},  A_DATA,  64'(d));
  endtask

  // Reference model state for the random phase.
  int          m_state, m_owner, m_ptr, w;
  logic [3:0]  m_grant, prev_grant, req_prev;
  int          remain[NB];
  int          waitcnt[NB];
  logic [7:0]  opv;

  initial begin
    reset  = 1'b1;
    req_a  = '0;
    hit_a  = '0;
    data_a = {32'hDEAD_BEEF, 32'h1111_1111};
    addr_a = {32'h0000_0040, 32'h0000_0100};
    op_a   = {2'b10, 2'b00};
    req_b  = '0;
    hit_b  = '0;
    op_b   = {2'b01, 2'b00, 2'b01, 2'b10};
    for (int i = 0; i < int'(NB); i++) begin
      data_b[32*i +: 32] = 32'hA000_0000 + 32'(i);
      addr_b[32*i +: 32] = 32'h0000_1000 + 32'(i);
      remain[i]  = 0;
      waitcnt[i] = 0;
    end

    // Reset held with no requests.
    for (int i = 0; i < 5; i++) begin
      exp_idle_a("rst");
      push("rst_owner", A_OWNER, 64'd0);
      push("rst_terr",  A_TERR,  64'd0);
      tick();
    end
    reset = 1'b0;
    exp_idle_a("idle");
    tick();

    // Both request: core0 first, then GAP, then core1.
    req_a = 2'b11;
    exp_own_a("own0", 2'b01, 1'b0, 2'b00, 32'h100, 32'h1111_1111);
    tick();
    push("own0_hold", A_GRANT, 64'd1);
    tick();
    req_a = 2'b10;
    exp_idle_a("gap");
    tick();
    exp_idle_a("gap_idle");
    tick();
    exp_own_a("own1", 2'b10, 1'b1, 2'b10, 32'h40, 32'hDEAD_BEEF);
    tick();

    // Snoop merge while core1 owns.
    hit_a = 2'b11;
    push("snoop_both", A_SNOOP, 64'd1);
    exp_own_a("own1_b", 2'b10, 1'b1, 2'b10, 32'h40, 32'hDEAD_BEEF);
    tick();
    hit_a = 2'b10;
    push("snoop_owner_only", A_SNOOP, 64'd0);
    tick();
    hit_a = 2'b01;
    push("snoop_other", A_SNOOP, 64'd1);
    tick();
    req_a = 2'b00;
    hit_a = 2'b11;
    exp_idle_a("rel1");
    push("snoop_gap", A_SNOOP, 64'd0);
    tick();
    push("snoop_idle", A_SNOOP, 64'd0);
    push("rel1_idle", A_GRANT, 64'd0);
    tick();
    hit_a = 2'b00;

    // Long hold by core0: timeout flags but grant persists.
    req_a = 2'b01;
    push("to_grant0", A_GRANT, 64'd1);
    push("to_owner0", A_OWNER, 64'd0);
    tick();
    for (int k = 1; k <= int'(MH) + 5; k++) begin
      push("to_grant", A_GRANT, 64'd1);
      if (k <= int'(MH) - 2) push("to_early", A_TERR, 64'd0);
      if (k >= int'(MH))     push("to_set",   A_TERR, 64'd1);
      tick();
    end
    req_a = 2'b00;
    push("to_rel_grant", A_GRANT, 64'd0);
    push("to_sticky",    A_TERR,  64'd1);
    tick();
    push("to_sticky2", A_TERR, 64'd1);
    tick();

    // Core1 owns, core0 request ignored, then reset mid-ownership.
    req_a = 2'b10;
    push("r_grant1", A_GRANT, 64'd2);
    tick();
    req_a = 2'b11;
    push("r_hold", A_GRANT, 64'd2);
    push("r_hold_owner", A_OWNER, 64'd1);
    tick();
    reset = 1'b1;
    exp_idle_a("r_mid");
    push("r_mid_owner", A_OWNER, 64'd0);
    push("r_mid_terr",  A_TERR,  64'd0);
    tick();
    reset = 1'b0;
    push("r_after_grant", A_GRANT, 64'd1);
    push("r_after_owner", A_OWNER, 64'd0);
    tick();
    req_a = 2'b00;
    tick();

    // Random traffic on the four-core instance.
    reset = 1'b1;
    tick();
    reset      = 1'b0;
    m_state    = 0;
    m_owner    = 0;
    m_ptr      = 0;
    m_grant    = '0;
    prev_grant = '0;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < int'(NB); i++) begin
        if (req_b[i] && m_grant[i]) begin
          remain[i]--;
          if (remain[i] <= 0) req_b[i] = 1'b0;
        end else if (!req_b[i] && $urandom_range(0, 3) == 0) begin
          req_b[i]  = 1'b1;
          remain[i] = int'($urandom_range(1, 6));
        end
      end
      case (m_state)
        0: if (|req_b) begin
          w = m_ptr;
          for (int k = 0; k < int'(NB); k++) begin
            w = (m_ptr + k) % int'(NB);
            if (req_b[w]) break;
          end
          m_owner = w;
          m_state = 1;
          m_grant = 4'(1) << w;
        end
        1: if (!req_b[m_owner]) begin
          m_state = 2;
          m_grant = '0;
          m_ptr   = (m_owner + 1) % int'(NB);
        end
        default: m_state = 0;
      endcase
      opv = op_b;
      push("rnd_grant", B_GRANT, 64'(m_grant));
      push("rnd_op",   B_OP,   (m_state == 1) ? 64'(opv[2*m_owner +: 2]) : 64'd3);
      push("rnd_addr", B_ADDR, (m_state == 1) ? 64'(32'h1000 + 32'(m_owner)) : 64'd0);
      req_prev = req_b;
      tick();

      n_assert++;
      assert ($onehot0(grant_b)) else begin
        n_fail++;
        $error("FAIL rnd_onehot: observed %b expected onehot0", grant_b);
      end
      if (prev_grant != '0 && |(prev_grant & req_prev)) begin
        n_assert++;
        assert (grant_b === prev_grant) else begin
          n_fail++;
          $error("FAIL rnd_stable: observed %b expected %b", grant_b, prev_grant);
        end
      end
      if (grant_b != '0 && prev_grant == '0) begin
        for (int i = 0; i < int'(NB); i++) begin
          if (grant_b[i]) begin
            n_assert++;
            assert (waitcnt[i] <= 3 * int'(NB)) else begin
              n_fail++;
              $error("FAIL rnd_starve: observed %0d ownerships waited, expected <= %0d",
                     waitcnt[i], 3 * int'(NB));
            end
            waitcnt[i] = 0;
          end else if (req_prev[i]) begin
            waitcnt[i]++;
          end
        end
      end
      prev_grant = grant_b;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
